fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of 128-bit fetch-line entries buffered (power of 2, >=2).
REQ-002 SHALL have reset rst_i, asynchronous, active-high, and clock clk_i.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 flush_i  in  1  branch redirect; discard all buffered and in-flight line data.
REQ-006 fetch_valid_i  in  1  fetch line presented.
REQ-007 fetch_instr_i  in  128  four 32-bit instructions; slot n = bits [32n+31:32n].
REQ-008 fetch_pred_branch_i  in  4  per-slot predicted-taken flags.
REQ-009 fetch_fault_fetch_i / fetch_fault_page_i  in  1 each  line fetch error / page fault.
REQ-010 fetch_pc_i  in  32  line address, bits [3:0] zero.
REQ-011 fetch_accept_o  out  1  queue can take a line this cycle.
REQ-012 out_valid_o  out  1  instruction presented to decode.
REQ-013 out_accept_i  in  1  decode consumes the presented instruction.
REQ-014 out_instr_o 32, out_pc_o 32, out_pred_taken_o 1, out_fault_fetch_o 1, out_fault_page_o 1  out  presented instruction and attributes.

Function
REQ-015 Push SHALL occur when fetch_valid_i & fetch_accept_o & !flush_i; line (instr, pred, pc, both faults) written at tail, tail++ mod DEPTH.
REQ-016 fetch_accept_o SHALL equal (count != DEPTH); no same-cycle pop credit.
REQ-017 Pushed line SHALL first be visible on out_* the cycle after push (no bypass, latency 1).
REQ-018 out_valid_o SHALL equal (count != 0) & !flush_i.
REQ-019 Presented slot SHALL be head line, slot index slot_q (2 bits); out_instr_o = that slot's word; out_pred_taken_o = pred[slot_q].
REQ-020 out_pc_o SHALL equal {head_pc[31:4], slot_q, 2'b00}.
REQ-021 Faulted line (either fault bit set) SHALL present exactly one entry: slot 0, fault bits set, out_pred_taken_o 0, out_instr_o 0.
REQ-022 Slot is last-of-line when slot_q==3, or pred[slot_q]==1, or line is faulted.
REQ-023 Handshake (out_valid_o & out_accept_i) on non-last slot SHALL increment slot_q; on last slot SHALL pop head (head++ mod DEPTH, count--) and clear slot_q to 0.
REQ-024 Slots after a predicted-taken slot SHALL never be presented.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-026 Push when count==DEPTH SHALL not occur (accept low); fetch_valid_i held by producer.
REQ-027 flush_i SHALL next cycle set count=0, head=tail=0, slot_q=0; same-cycle push and pop suppressed; flush dominates all events.
REQ-028 Outputs out_instr_o/out_pc_o/flags with out_valid_o low SHALL be don't-care to consumer but deterministic (driven from head storage).

Reset
REQ-029 On rst_i: count=0, head=0, tail=0, slot_q=0; hence out_valid_o=0, fetch_accept_o=1.
REQ-030 Line storage SHALL not require reset; reset mid-operation discards all contents immediately (asynchronous).

Structure
REQ-031 Line width 128, slots-per-line 4, instruction width 32, pc width 32 SHALL be constants in shared defs.v.
REQ-032 Storage as DEPTH x 166-bit register array, packing {fault_page, fault_fetch, pred[3:0], pc[31:0], instr[127:0]}, same order as the fetch skid buffer.
REQ-033 No sub-module; storage, pointers and slot counter inline.

Verification
REQ-034 Push line pc=0x1000, pred=0, no fault, out_accept_i=1 -> out_pc_o 0x1000,0x1004,0x1008,0x100C on cycles 1-4 after push, then out_valid_o=0.
REQ-035 Push line pc=0x2000, pred=4'b0010 -> only 0x2000 and 0x2004 presented, second with out_pred_taken_o=1; next line follows immediately.
REQ-036 Push line with fault_page=1, pc=0x3000 -> single entry out_pc_o=0x3000, out_fault_page_o=1, line popped on accept.
REQ-037 out_accept_i=0, push 2 lines (DEPTH=2) -> fetch_accept_o=0; third line held; after first line's 4 accepts, fetch_accept_o=1 and third line enters.
REQ-038 flush_i asserted with count=2, slot_q=2 and concurrent push -> next cycle out_valid_o=0, fetch_accept_o=1, pushed line absent.
REQ-039 Assert rst_i mid-stream with count=1 -> out_valid_o=0 immediately, fetch_accept_o=1, slot_q=0 after release.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch-line geometry and storage layout for the fetch queue.
//   LINE_W / SLOTS / INSTR_W / PC_W - line, slot-count, instruction and address widths
//   fq_line_t                       - one buffered line, packed in the same order as the
//                                     fetch skid buffer: {fault_page, fault_fetch, pred, pc, instr}
package fetch_queue_pkg;

  localparam int LINE_W  = 128;
  localparam int SLOTS   = 4;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int SLOT_W  = $clog2(SLOTS);

  typedef logic [SLOTS-1:0][INSTR_W-1:0] fq_instr_t;

  // 1 + 1 + 4 + 32 + 128 = 166 bits per entry.
  typedef struct packed {
    logic             fault_page;
    logic             fault_fetch;
    logic [SLOTS-1:0] pred;
    logic [PC_W-1:0]  pc;
    fq_instr_t        instr;
  } fq_line_t;

  function automatic logic line_faulted(input fq_line_t line);
    return line.fault_fetch | line.fault_page;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: buffers DEPTH 128-bit fetch lines and hands their instructions to decode
// one 32-bit slot at a time.
//   clk_i, rst_i (async, active-high)
//   flush_i                              - branch redirect, empties the queue next cycle
//   fetch_valid_i / fetch_accept_o       - line push handshake
//   fetch_instr_i, fetch_pred_branch_i,
//   fetch_fault_fetch_i, fetch_fault_page_i, fetch_pc_i - pushed line contents
//   out_valid_o / out_accept_i           - per-instruction handshake to decode
//   out_instr_o, out_pc_o, out_pred_taken_o,
//   out_fault_fetch_o, out_fault_page_o  - presented instruction and attributes
// A faulted line presents a single entry (slot 0, instruction zero). A slot predicted
// taken ends its line; later slots of that line are dropped.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               fetch_valid_i,
  input  logic [LINE_W-1:0]  fetch_instr_i,
  input  logic [SLOTS-1:0]   fetch_pred_branch_i,
  input  logic               fetch_fault_fetch_i,
  input  logic               fetch_fault_page_i,
  input  logic [PC_W-1:0]    fetch_pc_i,
  output logic               fetch_accept_o,
  output logic               out_valid_o,
  input  logic               out_accept_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [PC_W-1:0]    out_pc_o,
  output logic               out_pred_taken_o,
  output logic               out_fault_fetch_o,
  output logic               out_fault_page_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fq_line_t          mem [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [SLOT_W-1:0] slot_q;

  fq_line_t wr_line;
  fq_line_t head_line;
  logic     head_faulted;
  logic     push;
  logic     fire;
  logic     last_slot;
  logic     pop;
  logic     unused_pc_lo;

  assign wr_line = '{
    fault_page:  fetch_fault_page_i,
    fault_fetch: fetch_fault_fetch_i,
    pred:        fetch_pred_branch_i,
    pc:          fetch_pc_i,
    instr:       fetch_instr_i
  };

  assign head_line    = mem[head_q];
  assign head_faulted = line_faulted(head_line);

  // Line addresses are 16-byte aligned; the low bits are stored only to keep the
  // entry layout identical to the skid buffer.
  assign unused_pc_lo = ^head_line.pc[3:0];

  // No pop credit: a full queue refuses a line even if the head retires this cycle.
  assign fetch_accept_o = (count_q != CNT_W'(DEPTH));
  assign out_valid_o    = (count_q != '0) & ~flush_i;

  assign push      = fetch_valid_i & fetch_accept_o & ~flush_i;
  assign fire      = out_valid_o & out_accept_i;
  assign last_slot = (slot_q == SLOT_W'(SLOTS - 1)) | head_line.pred[slot_q] | head_faulted;
  assign pop       = fire & last_slot;

  assign out_pc_o          = {head_line.pc[PC_W-1:4], slot_q, 2'b00};
  assign out_fault_fetch_o = head_line.fault_fetch;
  assign out_fault_page_o  = head_line.fault_page;

  // NOTE: every output of an always_comb gets a default on entry so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    out_instr_o      = head_line.instr[slot_q];
    out_pred_taken_o = head_line.pred[slot_q];
    if (head_faulted) begin
      out_instr_o      = '0;
      out_pred_taken_o = 1'b0;
    end
  end

  // NOTE: line storage has no reset; the pointers and count alone decide what is
  // valid, so a reset or flush never has to touch the data array.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[tail_q] <= wr_line;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      slot_q  <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      slot_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is natural overflow.
      if (push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
        slot_q <= '0;
      end else if (fire) begin
        slot_q <= slot_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 2;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         fetch_valid_i;
  logic [127:0] fetch_instr_i;
  logic [3:0]   fetch_pred_branch_i;
  logic         fetch_fault_fetch_i;
  logic         fetch_fault_page_i;
  logic [31:0]  fetch_pc_i;
  logic         fetch_accept_o;
  logic         out_valid_o;
  logic         out_accept_i;
  logic [31:0]  out_instr_o;
  logic [31:0]  out_pc_o;
  logic         out_pred_taken_o;
  logic         out_fault_fetch_o;
  logic         out_fault_page_o;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_instr_i       (fetch_instr_i),
    .fetch_pred_branch_i (fetch_pred_branch_i),
    .fetch_fault_fetch_i (fetch_fault_fetch_i),
    .fetch_fault_page_i  (fetch_fault_page_i),
    .fetch_pc_i          (fetch_pc_i),
    .fetch_accept_o      (fetch_accept_o),
    .out_valid_o         (out_valid_o),
    .out_accept_i        (out_accept_i),
    .out_instr_o         (out_instr_o),
    .out_pc_o            (out_pc_o),
    .out_pred_taken_o    (out_pred_taken_o),
    .out_fault_fetch_o   (out_fault_fetch_o),
    .out_fault_page_o    (out_fault_page_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic        ff;
    logic        fp;
  } exp_t;

  exp_t sb[$];
  exp_t sb_exp;
  exp_t sb_got;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] word_of(input logic [31:0] pc, input int n);
    return pc ^ (32'h1111_0000 * (n + 1)) ^ 32'h0000_0A50;
  endfunction

  // Expected decode stream for one pushed line.
  task automatic model_line(input logic [31:0] pc, input logic [127:0] instr,
                            input logic [3:0] pred, input logic ff, input logic fp);
    exp_t e;
    if (ff || fp) begin
      e = '{pc: pc, instr: 32'h0, pred: 1'b0, ff: ff, fp: fp};
      sb.push_back(e);
    end else begin
      for (int s = 0; s < 4; s++) begin
        e = '{pc: pc + 32'(4 * s), instr: instr[32*s +: 32], pred: pred[s], ff: 1'b0, fp: 1'b0};
        sb.push_back(e);
        if (pred[s]) break;
      end
    end
  endtask

  // Scoreboard: samples at the falling edge the handshakes that the next rising edge commits.
  always @(negedge clk_i) begin
    if (rst_i || flush_i) begin
      sb.delete();
    end else begin
      if (out_valid_o && out_accept_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h with nothing expected", out_pc_o, out_instr_o);
        end else begin
          sb_exp = sb.pop_front();
          sb_got = {out_pc_o, out_instr_o, out_pred_taken_o, out_fault_fetch_o, out_fault_page_o};
          if (sb_got !== sb_exp) begin
            errors++;
            $display("FAIL sb_entry: got pc=%h instr=%h pt=%b ff=%b fp=%b, expected pc=%h instr=%h pt=%b ff=%b fp=%b",
                     sb_got.pc, sb_got.instr, sb_got.pred, sb_got.ff, sb_got.fp,
                     sb_exp.pc, sb_exp.instr, sb_exp.pred, sb_exp.ff, sb_exp.fp);
          end
        end
      end
      if (fetch_valid_i && fetch_accept_o) begin
        model_line(fetch_pc_i, fetch_instr_i, fetch_pred_branch_i, fetch_fault_fetch_i, fetch_fault_page_i);
      end
    end
  end

  task automatic drive_line(input logic [31:0] pc, input logic [3:0] pred,
                            input logic ff, input logic fp);
    fetch_valid_i       = 1'b1;
    fetch_pc_i          = pc;
    fetch_pred_branch_i = pred;
    fetch_fault_fetch_i = ff;
    fetch_fault_page_i  = fp;
    for (int n = 0; n < 4; n++) fetch_instr_i[32*n +: 32] = word_of(pc, n);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (!out_valid_o) break;
    end
    checks++;
    if (out_valid_o !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: out_valid=%b pending=%0d, expected 0 and 0", name, out_valid_o, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; out_accept_i = 1'b0;
    fetch_instr_i = '0; fetch_pred_branch_i = '0; fetch_pc_i = '0;
    fetch_fault_fetch_i = 1'b0; fetch_fault_page_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || fetch_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b fetch_accept=%b, expected 0 1", out_valid_o, fetch_accept_o);
    end
    @(posedge clk_i); #1 rst_i = 1'b0;
  endtask

  task automatic test_sequential();
    @(posedge clk_i); #1;
    out_accept_i = 1'b1;
    drive_line(32'h1000, 4'b0000, 1'b0, 1'b0);
    @(posedge clk_i); #1 fetch_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++;
      if (out_valid_o !== 1'b1 || out_pc_o !== 32'h1000 + 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_slot%0d: valid=%b pc=%h, expected 1 %h", i, out_valid_o, out_pc_o, 32'h1000 + 32'(4 * i));
      end
    end
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL seq_empty: valid=%b, expected 0", out_valid_o);
    end
  endtask

  task automatic test_pred_taken();
    logic [31:0] exp_pc [6];
    logic        exp_pt [6];
    exp_pc = '{32'h2000, 32'h2004, 32'h2100, 32'h2104, 32'h2108, 32'h210C};
    exp_pt = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    @(posedge clk_i); #1;
    out_accept_i = 1'b1;
    drive_line(32'h2000, 4'b0010, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    drive_line(32'h2100, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      checks++;
      if (out_valid_o !== 1'b1 || out_pc_o !== exp_pc[i] || out_pred_taken_o !== exp_pt[i]) begin
        errors++;
        $display("FAIL pred_step%0d: valid=%b pc=%h pt=%b, expected 1 %h %b",
                 i, out_valid_o, out_pc_o, out_pred_taken_o, exp_pc[i], exp_pt[i]);
      end
      if (i == 0) begin
        @(posedge clk_i); #1 fetch_valid_i = 1'b0;
      end
    end
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL pred_empty: valid=%b, expected 0", out_valid_o);
    end
  endtask

  task automatic test_fault();
    @(posedge clk_i); #1;
    out_accept_i = 1'b1;
    drive_line(32'h3000, 4'b1111, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    drive_line(32'h3100, 4'b0000, 1'b1, 1'b0);
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b1 || out_pc_o !== 32'h3000 || out_fault_page_o !== 1'b1 ||
        out_fault_fetch_o !== 1'b0 || out_instr_o !== 32'h0 || out_pred_taken_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_page: valid=%b pc=%h fp=%b ff=%b instr=%h pt=%b, expected 1 00003000 1 0 00000000 0",
               out_valid_o, out_pc_o, out_fault_page_o, out_fault_fetch_o, out_instr_o, out_pred_taken_o);
    end
    @(posedge clk_i); #1 fetch_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b1 || out_pc_o !== 32'h3100 || out_fault_fetch_o !== 1'b1 || out_fault_page_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_fetch: valid=%b pc=%h ff=%b fp=%b, expected 1 00003100 1 0",
               out_valid_o, out_pc_o, out_fault_fetch_o, out_fault_page_o);
    end
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_empty: valid=%b, expected 0", out_valid_o);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk_i); #1;
    out_accept_i = 1'b0;
    drive_line(32'h4000, 4'b0000, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    drive_line(32'h4100, 4'b0100, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    drive_line(32'h4200, 4'b0000, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (fetch_accept_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: fetch_accept=%b, expected 0", fetch_accept_o);
    end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (fetch_accept_o !== 1'b0 || out_pc_o !== 32'h4000) begin
      errors++;
      $display("FAIL bp_hold: fetch_accept=%b pc=%h, expected 0 00004000", fetch_accept_o, out_pc_o);
    end
    @(posedge clk_i); #1 out_accept_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (fetch_accept_o !== 1'b0 || out_pc_o !== 32'h400C) begin
      errors++;
      $display("FAIL bp_last_slot: fetch_accept=%b pc=%h, expected 0 0000400c", fetch_accept_o, out_pc_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (fetch_accept_o !== 1'b1 || out_pc_o !== 32'h4100) begin
      errors++;
      $display("FAIL bp_release: fetch_accept=%b pc=%h, expected 1 00004100", fetch_accept_o, out_pc_o);
    end
    @(posedge clk_i); #1 fetch_valid_i = 1'b0;
    drain("bp");
  endtask

  task automatic test_flush();
    @(posedge clk_i); #1;
    out_accept_i = 1'b0;
    drive_line(32'h6000, 4'b0000, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    drive_line(32'h6100, 4'b0000, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    out_accept_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    drive_line(32'h6200, 4'b0000, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0 || out_pc_o !== 32'h6008 || fetch_accept_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle: valid=%b pc=%h accept=%b, expected 0 00006008 0",
               out_valid_o, out_pc_o, fetch_accept_o);
    end
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0 || fetch_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_next: valid=%b accept=%b, expected 0 1", out_valid_o, fetch_accept_o);
    end
    // Flush while the queue has room: the concurrent push must still be dropped.
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    drive_line(32'h6300, 4'b0000, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0 || fetch_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_push_dropped: valid=%b accept=%b, expected 0 1", out_valid_o, fetch_accept_o);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk_i); #1;
    out_accept_i = 1'b0;
    drive_line(32'h7000, 4'b0000, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    out_accept_i  = 1'b1;
    @(posedge clk_i); #1;
    out_accept_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || fetch_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: valid=%b accept=%b, expected 0 1", out_valid_o, fetch_accept_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    out_accept_i = 1'b1;
    drive_line(32'h7100, 4'b0000, 1'b0, 1'b0);
    @(posedge clk_i); #1 fetch_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b1 || out_pc_o !== 32'h7100) begin
      errors++;
      $display("FAIL reset_slot0: valid=%b pc=%h, expected 1 00007100", out_valid_o, out_pc_o);
    end
    drain("reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    logic [3:0]  pred;
    logic        ff;
    logic        fp;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk_i); #1;
      out_accept_i = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 49) == 0);
      pc   = $urandom() & 32'hFFFF_FFF0;
      pred = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      ff   = ($urandom_range(0, 15) == 0);
      fp   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) != 0) drive_line(pc, pred, ff, fp);
      else fetch_valid_i = 1'b0;
    end
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    out_accept_i = 1'b1;
    drain("b2b");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_pred_taken();
    test_fault();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
